turn_ctl: RTL and testbench
===========================

Name: turn_ctl

Overview:
- Game sequencer for the tic-tac-toe board register block (the square occupancy/colour register driven by the mouse and the UART).
- Decides whose turn it is and gates local mouse clicks to the local turn only.
- Forwards each local move code to the UART transmitter; validates received move codes before letting the board block apply them.
- Evaluates win/draw after every move and reports the result; sits between mouse, UART and board block in the top level.

Parameters:
- NSQ, 9, number of board squares (fixed 3x3; not meant to be overridden).

Ports:
- pclk  in  1  system pixel clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- start_en  in  1  game screen active; low forces IDLE
- choice_en  in  1  player-choice menu active; high holds IDLE
- playerID  in  1  local player: 0 = BLUE (moves first), 1 = YELLOW
- mouse_left  in  1  raw left-button level
- square1to9  in  9  board occupancy from board block
- square1to9_color  in  9  board colour from board block (0 = BLUE, 1 = YELLOW)
- w_data  in  8  move code of the latest local move, from board block
- rx_done  in  1  one-cycle pulse: rec_data valid
- rec_data  in  8  received byte
- tx_full  in  1  UART transmit FIFO full
- mouse_click  out  1  gated mouse_left to board block (combinational)
- write_uart_en  out  1  one-cycle pulse: board block applies rec_data
- wr_uart  out  1  one-cycle transmit strobe
- tx_data  out  8  byte to transmit
- my_turn  out  1  high while local player may move
- result  out  2  00 none, 01 BLUE wins, 10 YELLOW wins, 11 draw
- game_over  out  1  high in OVER
- rx_err  out  1  sticky illegal/occupied receive flag; cleared in IDLE

Behaviour:
- Reset values: all registered outputs 0; state IDLE; board snapshot 0; arm 0.
- Move code format: bits[7:6] = 00; bits[5:3] one-hot row (100 top, 010 mid, 001 bottom); bits[2:0] one-hot column (100 left, 010 mid, 001 right).
  - Square index = 3*row + col; e.g. 8'h24 -> sq0, 8'h12 -> sq4, 8'h09 -> sq8.
- Turn flag: registered, 0 = BLUE.
- IDLE:
  - Entry conditions: start_en && !choice_en.
  - On entry: snapshot <= square1to9, turn <= BLUE, result <= 00, rx_err <= 0.
  - Next state: LOCAL if playerID == 0, else REMOTE.
- LOCAL (my_turn = 1):
  - arm sets on any cycle with mouse_left == 0; mouse_click = mouse_left & arm & (state == LOCAL).
  - A button held across the turn boundary is ignored until released.
  - New move = any bit of square1to9 & ~snapshot. On detect: tx_data <= w_data (same cycle), snapshot <= square1to9, arm <= 0, go TXS.
- TXS: while tx_full, wait. Otherwise wr_uart = 1 for exactly one cycle, go CHECK.
- REMOTE (my_turn = 0):
  - On rx_done, the byte is legal iff it is a valid code AND the target square is unoccupied.
  - Legal: write_uart_en = 1 next cycle (one cycle), go UPD.
  - Illegal: rx_err <= 1, stay in REMOTE.
  - rx_done outside REMOTE is ignored.
- UPD: one wait cycle for the board block's register; snapshot <= square1to9; go CHECK.
- CHECK:
  - Evaluate 8 lines (3 rows, 3 cols, 2 diagonals); a line wins if all three squares are occupied with equal colour.
  - Any win: result = 01/10 by that colour.
  - Otherwise all 9 occupied: result = 11.
  - Otherwise: toggle turn, go LOCAL or REMOTE per turn == playerID.
  - result != 00 -> OVER.
- OVER: game_over = 1; result held; exit to IDLE when start_en drops.
- Global rules:
  - start_en low or choice_en high in any state -> IDLE next cycle.
  - Any pending wr_uart/write_uart_en is suppressed.
- Latency: local move detect -> wr_uart ≥ 1 cycle; rx_done -> write_uart_en 1 cycle; rx_done -> result valid 3 cycles.
- Reset mid-game: immediate IDLE, all outputs 0.

Decomposition:
- Package tt_pkg:
  - state encoding (IDLE, LOCAL, TXS, REMOTE, UPD, CHECK, OVER);
  - BLUE/YELLOW constants;
  - RES_NONE/RES_BLUE/RES_YELLOW/RES_DRAW;
  - function code_to_index and function code_valid.
- Sub-module win_check (combinational): in square1to9/colour; out win, win_colour, full.

Test Plan:
- playerID = 0, start_en rises → state LOCAL, my_turn = 1; board block sets sq4 with w_data = 8'h12 and tx_full = 0 → wr_uart pulse, tx_data = 8'h12, my_turn = 0.
- In REMOTE, rx_done with rec_data = 8'h24 → write_uart_en one-cycle pulse; after UPD/CHECK, my_turn = 1.
- In REMOTE, rec_data = 8'h12 (sq4 occupied) or 8'h66 (bad code) → no write_uart_en, rx_err = 1, still REMOTE.
- BLUE occupies sq0, sq1, sq2 → result = 01, game_over = 1; a further rx_done is ignored.
- Full board, no line → result = 11. tx_full held 20 cycles in TXS → no wr_uart until release, then exactly one pulse.
- mouse_left held high entering LOCAL → mouse_click = 0 until mouse_left low then high; start_en dropped mid-TXS → IDLE, no wr_uart.

Source files
------------

// File: rtl/tt_pkg.sv
// ---------------------------------------------------------------------------
// tt_pkg - shared definitions for the tic-tac-toe turn sequencer.
//   * sequencer state encoding
//   * player colour and game-result encodings
//   * move-code helpers: code_valid / code_to_index
//   * line_sq: square index of the k-th cell of one of the 8 winning lines
// Square numbering: index = 3*row + col, row 0 = top, col 0 = left.
// ---------------------------------------------------------------------------
package tt_pkg;

  localparam int NSQ = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_TXS,
    S_REMOTE,
    S_UPD,
    S_CHECK,
    S_OVER
  } state_t;

  localparam logic BLUE   = 1'b0;
  localparam logic YELLOW = 1'b1;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_BLUE   = 2'b01;
  localparam logic [1:0] RES_YELLOW = 2'b10;
  localparam logic [1:0] RES_DRAW   = 2'b11;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

  // MSB of the one-hot field is position 0 (top row / left column).
  function automatic logic [1:0] onehot3_to_idx(input logic [2:0] v);
    logic [1:0] idx;
    case (v)
      3'b100:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      default: idx = 2'd2;
    endcase
    return idx;
  endfunction

  function automatic logic code_valid(input logic [7:0] code);
    return (code[7:6] == 2'b00) && is_onehot3(code[5:3]) && is_onehot3(code[2:0]);
  endfunction

  // Only meaningful when code_valid(code) is true.
  function automatic logic [3:0] code_to_index(input logic [7:0] code);
    logic [3:0] row;
    logic [3:0] col;
    row = {2'b00, onehot3_to_idx(code[5:3])};
    col = {2'b00, onehot3_to_idx(code[2:0])};
    return row * 4'd3 + col;
  endfunction

  // Lines 0-2: rows, 3-5: columns, 6: main diagonal, 7: anti-diagonal.
  function automatic int line_sq(input int line, input int k);
    int sq;
    if (line < 3)      sq = 3 * line + k;
    else if (line < 6) sq = (line - 3) + 3 * k;
    else if (line == 6) sq = 4 * k;
    else               sq = 2 + 2 * k;
    return sq;
  endfunction

endpackage

// File: rtl/win_check.sv
// ---------------------------------------------------------------------------
// win_check - combinational board evaluator.
// Ports:
//   square     in  9  occupancy (bit i = square i)
//   colour     in  9  colour of each square (0 BLUE, 1 YELLOW)
//   win        out 1  some line holds three squares of one colour
//   win_colour out 1  colour of the winning line (lowest-numbered line wins ties)
//   full       out 1  all squares occupied
// ---------------------------------------------------------------------------
module win_check
  import tt_pkg::*;
(
  input  logic [NSQ-1:0] square,
  input  logic [NSQ-1:0] colour,
  output logic           win,
  output logic           win_colour,
  output logic           full
);

  logic [7:0] line_win;
  logic [7:0] line_col;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam int SA = line_sq(gi, 0);
      localparam int SB = line_sq(gi, 1);
      localparam int SC = line_sq(gi, 2);
      assign line_win[gi] = square[SA] & square[SB] & square[SC] &
                            (colour[SA] == colour[SB]) & (colour[SB] == colour[SC]);
      assign line_col[gi] = colour[SA];
    end
  endgenerate

  always_comb begin
    win_colour = BLUE;
    for (int i = 7; i >= 0; i--) begin
      if (line_win[i]) win_colour = line_col[i];
    end
  end

  assign win  = |line_win;
  assign full = &square;

endmodule

// File: rtl/turn_ctl.sv
// ---------------------------------------------------------------------------
// turn_ctl - tic-tac-toe game sequencer between mouse, UART and board block.
// Ports:
//   pclk, rst (async, active-low)
//   start_en, choice_en   game screen / menu enables (IDLE unless 1/0)
//   playerID              local colour (0 BLUE moves first, 1 YELLOW)
//   mouse_left            raw left button
//   square1to9[_color]    board occupancy / colour from board block
//   w_data                code of latest local move
//   rx_done, rec_data     received byte strobe and data
//   tx_full               UART TX FIFO full
//   mouse_click           gated button to board block (combinational)
//   write_uart_en         one-cycle: board applies rec_data
//   wr_uart, tx_data      one-cycle TX strobe and byte
//   my_turn, game_over    LOCAL / OVER state indicators
//   result                00 none, 01 BLUE, 10 YELLOW, 11 draw
//   rx_err                sticky bad-receive flag, cleared in IDLE
// ---------------------------------------------------------------------------
module turn_ctl
  import tt_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       start_en,
  input  logic       choice_en,
  input  logic       playerID,
  input  logic       mouse_left,
  input  logic [8:0] square1to9,
  input  logic [8:0] square1to9_color,
  input  logic [7:0] w_data,
  input  logic       rx_done,
  input  logic [7:0] rec_data,
  input  logic       tx_full,
  output logic       mouse_click,
  output logic       write_uart_en,
  output logic       wr_uart,
  output logic [7:0] tx_data,
  output logic       my_turn,
  output logic [1:0] result,
  output logic       game_over,
  output logic       rx_err
);

  state_t     state_reg, state_next;
  logic       turn_reg, turn_next;
  logic [8:0] snapshot_reg, snapshot_next;
  logic       arm_reg, arm_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [1:0] result_reg, result_next;
  logic       rx_err_reg, rx_err_next;
  logic       wue_reg, wue_next;

  logic go_ok;
  logic new_move;
  logic rx_legal;
  logic win;
  logic win_colour;
  logic full;

  win_check u_win_check (
    .square     (square1to9),
    .colour     (square1to9_color),
    .win        (win),
    .win_colour (win_colour),
    .full       (full)
  );

  assign go_ok    = start_en && !choice_en;
  assign new_move = |(square1to9 & ~snapshot_reg);
  assign rx_legal = code_valid(rec_data) && !square1to9[code_to_index(rec_data)];

  always_comb begin
    state_next    = state_reg;
    turn_next     = turn_reg;
    snapshot_next = snapshot_reg;
    tx_data_next  = tx_data_reg;
    result_next   = result_reg;
    rx_err_next   = rx_err_reg;
    wue_next      = 1'b0;
    wr_uart       = 1'b0;
    // Arm only after the button has been seen released, so a press held
    // across a turn boundary never produces a click.
    arm_next      = arm_reg | ~mouse_left;

    case (state_reg)
      S_IDLE: begin
        arm_next    = 1'b0;
        result_next = RES_NONE;
        rx_err_next = 1'b0;
        if (go_ok) begin
          snapshot_next = square1to9;
          turn_next     = BLUE;
          state_next    = (playerID == BLUE) ? S_LOCAL : S_REMOTE;
        end
      end
      S_LOCAL: begin
        if (new_move) begin
          tx_data_next  = w_data;
          snapshot_next = square1to9;
          arm_next      = 1'b0;
          state_next    = S_TXS;
        end
      end
      S_TXS: begin
        if (!tx_full) begin
          wr_uart    = 1'b1;
          state_next = S_CHECK;
        end
      end
      S_REMOTE: begin
        if (rx_done) begin
          if (rx_legal) begin
            wue_next   = 1'b1;
            state_next = S_UPD;
          end else begin
            rx_err_next = 1'b1;
          end
        end
      end
      S_UPD: begin
        snapshot_next = square1to9;
        state_next    = S_CHECK;
      end
      S_CHECK: begin
        // The board register applies a remote move at the end of UPD, so the
        // snapshot is refreshed again here; otherwise that move would be
        // mistaken for a new local move on the next LOCAL turn.
        snapshot_next = square1to9;
        if (win) begin
          result_next = (win_colour == YELLOW) ? RES_YELLOW : RES_BLUE;
          state_next  = S_OVER;
        end else if (full) begin
          result_next = RES_DRAW;
          state_next  = S_OVER;
        end else begin
          turn_next  = ~turn_reg;
          state_next = (~turn_reg == playerID) ? S_LOCAL : S_REMOTE;
        end
      end
      S_OVER: begin
      end
      default: state_next = S_IDLE;
    endcase

    // Leaving the game screen aborts everything, including pending strobes.
    if (!go_ok) begin
      state_next = S_IDLE;
      wr_uart    = 1'b0;
      wue_next   = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      turn_reg     <= BLUE;
      snapshot_reg <= '0;
      arm_reg      <= 1'b0;
      tx_data_reg  <= '0;
      result_reg   <= RES_NONE;
      rx_err_reg   <= 1'b0;
      wue_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      turn_reg     <= turn_next;
      snapshot_reg <= snapshot_next;
      arm_reg      <= arm_next;
      tx_data_reg  <= tx_data_next;
      result_reg   <= result_next;
      rx_err_reg   <= rx_err_next;
      wue_reg      <= wue_next;
    end
  end

  assign mouse_click   = mouse_left & arm_reg & (state_reg == S_LOCAL);
  assign write_uart_en = wue_reg;
  assign tx_data       = tx_data_reg;
  assign my_turn       = (state_reg == S_LOCAL);
  assign game_over     = (state_reg == S_OVER);
  assign result        = result_reg;
  assign rx_err        = rx_err_reg;

endmodule

// File: tb/tb_turn_ctl.sv
// ---------------------------------------------------------------------------
// tb_turn_ctl - self-checking bench for turn_ctl.
// The bench plays the board block: it owns the board vectors, applies local
// moves directly and remote moves when write_uart_en is seen. Expected TX
// bytes, applied codes and game results are queued at stimulus time and
// popped by an independent monitor when the DUT strobes them.
// ---------------------------------------------------------------------------
module tb_turn_ctl;

  logic       pclk = 1'b0;
  logic       rst;
  logic       start_en;
  logic       choice_en;
  logic       playerID;
  logic       mouse_left;
  logic [8:0] square1to9;
  logic [8:0] square1to9_color;
  logic [7:0] w_data;
  logic       rx_done;
  logic [7:0] rec_data;
  logic       tx_full;
  logic       mouse_click;
  logic       write_uart_en;
  logic       wr_uart;
  logic [7:0] tx_data;
  logic       my_turn;
  logic [1:0] result;
  logic       game_over;
  logic       rx_err;

  turn_ctl dut (
    .pclk             (pclk),
    .rst              (rst),
    .start_en         (start_en),
    .choice_en        (choice_en),
    .playerID         (playerID),
    .mouse_left       (mouse_left),
    .square1to9       (square1to9),
    .square1to9_color (square1to9_color),
    .w_data           (w_data),
    .rx_done          (rx_done),
    .rec_data         (rec_data),
    .tx_full          (tx_full),
    .mouse_click      (mouse_click),
    .write_uart_en    (write_uart_en),
    .wr_uart          (wr_uart),
    .tx_data          (tx_data),
    .my_turn          (my_turn),
    .result           (result),
    .game_over        (game_over),
    .rx_err           (rx_err)
  );

  initial forever #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_wue[$];
  logic [1:0] exp_res[$];

  // reference model state
  logic pid;
  int   turn;       // 0 BLUE to move, 1 YELLOW
  int   res_model;  // 0 none, 1 blue, 2 yellow, 3 draw

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] code_of(input int sq);
    logic [2:0] r;
    logic [2:0] c;
    r = 3'b100 >> (sq / 3);
    c = 3'b100 >> (sq % 3);
    return {2'b00, r, c};
  endfunction

  function automatic int ref_result(input logic [8:0] occ, input logic [8:0] col);
    for (int l = 0; l < 8; l++) begin
      if (occ[lines[l][0]] && occ[lines[l][1]] && occ[lines[l][2]] &&
          col[lines[l][0]] == col[lines[l][1]] && col[lines[l][1]] == col[lines[l][2]])
        return col[lines[l][0]] ? 2 : 1;
    end
    if (&occ) return 3;
    return 0;
  endfunction

  function automatic int pick(input logic [8:0] occ, input bit want_occupied);
    int cand[$];
    for (int i = 0; i < 9; i++) if (occ[i] == want_occupied) cand.push_back(i);
    if (cand.size() == 0) return 0;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  // Monitor: pops expectations whenever the DUT strobes an output.
  initial begin
    logic go_prev;
    go_prev = 1'b0;
    forever begin
      @(negedge pclk);
      if (rst) begin
        if (wr_uart) begin
          n_wr++;
          $display("tx byte %02h", tx_data);
          if (exp_tx.size() == 0) check_eq("unexpected_wr_uart", 1, 0);
          else check_eq("tx_data", tx_data, exp_tx.pop_front());
        end
        if (write_uart_en) begin
          $display("apply rx byte %02h", rec_data);
          if (exp_wue.size() == 0) check_eq("unexpected_write_uart_en", 1, 0);
          else check_eq("applied_code", rec_data, exp_wue.pop_front());
        end
        if (game_over && !go_prev) begin
          $display("game result %0d", result);
          if (exp_res.size() == 0) check_eq("unexpected_game_over", 1, 0);
          else check_eq("result", result, exp_res.pop_front());
        end
      end
      go_prev = game_over;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic wait_turn(input string name);
    int k;
    k = 0;
    while (!my_turn && k < 30) begin
      cyc(1);
      k++;
    end
    check_eq(name, my_turn, 1);
  endtask

  task automatic apply_move(input int sq, input logic c);
    square1to9[sq]       = 1'b1;
    square1to9_color[sq] = c;
    res_model = ref_result(square1to9, square1to9_color);
    if (res_model != 0) exp_res.push_back(2'(res_model));
    turn ^= 1;
  endtask

  task automatic post_move_checks();
    if (res_model != 0) begin
      check_eq("game_over_after_move", game_over, 1);
    end else begin
      check_eq("game_over_after_move", game_over, 0);
      check_eq("my_turn_after_move", my_turn, (turn == int'(pid)) ? 1 : 0);
    end
  endtask

  task automatic local_move(input int sq, input int hold);
    int wr0;
    wait_turn("my_turn_local");
    cyc(1);
    mouse_left = 1'b1;
    #1;
    check_eq("mouse_click", mouse_click, 1);
    cyc(1);
    mouse_left = 1'b0;
    wr0 = n_wr;
    tx_full = (hold > 0);
    w_data = code_of(sq);
    exp_tx.push_back(code_of(sq));
    apply_move(sq, pid);
    if (hold > 0) begin
      cyc(hold);
      check_eq("wr_uart_while_full", n_wr - wr0, 0);
      tx_full = 1'b0;
    end
    cyc(4);
    check_eq("wr_uart_count", n_wr - wr0, 1);
    post_move_checks();
  endtask

  task automatic remote_move(input logic [7:0] code);
    int sq;
    bit legal;
    sq = 0;
    legal = 0;
    for (int i = 0; i < 9; i++) begin
      if (!square1to9[i] && code_of(i) == code) begin
        legal = 1;
        sq = i;
      end
    end
    if (legal) exp_wue.push_back(code);
    check_eq("my_turn_remote", my_turn, 0);
    rec_data = code;
    rx_done  = 1'b1;
    cyc(1);
    rx_done  = 1'b0;
    check_eq("write_uart_en_pulse", write_uart_en, legal);
    if (legal && write_uart_en) begin
      cyc(1);
      apply_move(sq, ~pid);
      cyc(4);
      post_move_checks();
    end else begin
      cyc(2);
      if (!legal) check_eq("rx_err_set", rx_err, 1);
      check_eq("still_remote", my_turn, 0);
    end
  endtask

  task automatic new_game(input logic p);
    start_en = 1'b0;
    cyc(2);
    square1to9       = '0;
    square1to9_color = '0;
    res_model = 0;
    turn = 0;
    check_eq("idle_game_over", game_over, 0);
    check_eq("idle_result", result, 0);
    check_eq("idle_rx_err", rx_err, 0);
    check_eq("idle_my_turn", my_turn, 0);
    pid = p;
    playerID = p;
    start_en = 1'b1;
    cyc(2);
  endtask

  initial begin
    int wr0;
    rst = 1'b0;
    start_en = 1'b0;
    choice_en = 1'b0;
    playerID = 1'b0;
    mouse_left = 1'b1;
    square1to9 = '0;
    square1to9_color = '0;
    w_data = '0;
    rx_done = 1'b0;
    rec_data = '0;
    tx_full = 1'b0;
    pid = 1'b0;
    turn = 0;
    res_model = 0;
    cyc(3);
    check_eq("rst_my_turn", my_turn, 0);
    check_eq("rst_wr_uart", wr_uart, 0);
    check_eq("rst_write_uart_en", write_uart_en, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_game_over", game_over, 0);
    check_eq("rst_rx_err", rx_err, 0);
    check_eq("rst_mouse_click", mouse_click, 0);
    rst = 1'b1;
    cyc(1);

    // Game 1: held button, first move, illegal and legal receives.
    new_game(1'b0);
    wait_turn("my_turn_first");
    check_eq("held_button_click", mouse_click, 0);
    cyc(3);
    check_eq("held_button_click_later", mouse_click, 0);
    mouse_left = 1'b0;
    cyc(1);
    mouse_left = 1'b1;
    #1;
    check_eq("rearmed_click", mouse_click, 1);
    cyc(1);
    mouse_left = 1'b0;
    local_move(4, 0);
    remote_move(8'h12);
    remote_move(8'h66);
    remote_move(8'h24);
    check_eq("my_turn_after_remote", my_turn, 1);

    // Asynchronous reset mid-game.
    rst = 1'b0;
    #2;
    check_eq("async_rst_my_turn", my_turn, 0);
    check_eq("async_rst_rx_err", rx_err, 0);
    cyc(1);
    rst = 1'b1;

    // Game 2: BLUE wins the top row, later receive ignored.
    new_game(1'b0);
    local_move(0, 0);
    remote_move(code_of(3));
    local_move(1, 0);
    remote_move(code_of(4));
    local_move(2, 0);
    rec_data = 8'h09;
    rx_done  = 1'b1;
    cyc(1);
    rx_done  = 1'b0;
    check_eq("over_rx_ignored", write_uart_en, 0);
    cyc(2);
    check_eq("over_result_held", result, res_model);
    check_eq("over_game_over", game_over, 1);

    // Game 3: draw, local YELLOW, one move with a long FIFO-full stall.
    new_game(1'b1);
    remote_move(code_of(0));
    local_move(1, 0);
    remote_move(code_of(2));
    local_move(4, 20);
    remote_move(code_of(3));
    local_move(5, 0);
    remote_move(code_of(7));
    local_move(6, 0);
    remote_move(code_of(8));
    check_eq("draw_result", result, res_model);

    // Randomized games with occasional illegal receives and FIFO stalls.
    for (int g = 0; g < 6; g++) begin
      new_game(1'($urandom_range(0, 1)));
      while (res_model == 0) begin
        if (turn == int'(pid)) begin
          local_move(pick(square1to9, 0),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end else begin
          if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 1 && |square1to9)
              remote_move(code_of(pick(square1to9, 1)));
            else
              remote_move(8'(8'hC0 | $urandom_range(0, 63)));
          end
          remote_move(code_of(pick(square1to9, 0)));
        end
      end
    end

    // start_en dropped while stalled in TXS: no transmit strobe.
    new_game(1'b0);
    wait_turn("my_turn_drop");
    cyc(1);
    tx_full = 1'b1;
    wr0 = n_wr;
    w_data = code_of(4);
    square1to9[4] = 1'b1;
    cyc(3);
    start_en = 1'b0;
    cyc(1);
    tx_full = 1'b0;
    cyc(3);
    check_eq("drop_no_wr_uart", n_wr - wr0, 0);
    check_eq("drop_my_turn", my_turn, 0);
    check_eq("drop_game_over", game_over, 0);

    check_eq("pending_tx", exp_tx.size(), 0);
    check_eq("pending_write_uart_en", exp_wue.size(), 0);
    check_eq("pending_result", exp_res.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
